// File: rtl/game_ctrl_pkg.sv
// Shared constants for the Game-of-Life generation sequencer: FSM state
// encodings, window layout and per-cell timing.
package game_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_FETCH = 3'd1;
  localparam state_t ST_EVAL  = 3'd2;
  localparam state_t ST_WAIT  = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  // 3x3 window, row-major; bit index = (dy+1)*3 + (dx+1)
  localparam int WIN_BITS   = 9;
  localparam int WIN_CENTRE = 4;

  // FETCH runs 10 slots: 9 reads plus one slot to catch the last read data
  localparam int FETCH_SLOTS     = 10;
  localparam int FETCH_LAST_READ = 8;
  localparam int CYCLES_PER_CELL = 12;

  // Column offset (+1) of a fetch slot: 0,1,2 map to dx = -1,0,+1
  function automatic logic [3:0] slot_col(input logic [3:0] slot);
    return slot % 4'd3;
  endfunction

  // Row offset (+1) of a fetch slot: 0,1,2 map to dy = -1,0,+1
  function automatic logic [3:0] slot_row(input logic [3:0] slot);
    return slot / 4'd3;
  endfunction

endpackage

// File: rtl/game_neigh_addr.sv
// Neighbour address generator: maps a cell (x,y) and a fetch slot to the
// linear address of that neighbour, applying toroidal wrap or reporting
// that the neighbour lies outside the grid.
module game_neigh_addr
  import game_ctrl_pkg::*;
#(
  parameter int W    = 8,
  parameter int H    = 8,
  parameter int WRAP = 0,
  parameter int AW   = $clog2(W*H),
  parameter int XW   = $clog2(W),
  parameter int YW   = $clog2(H)
) (
  input  logic [XW-1:0] i_x,
  input  logic [YW-1:0] i_y,
  input  logic [3:0]    i_slot,
  output logic [AW-1:0] o_addr,
  output logic          o_in_grid
);

  // Coordinates are carried biased by +1 so that -1 becomes 0 and no
  // signed arithmetic is needed.
  logic [15:0] w_xp1;
  logic [15:0] w_yp1;
  logic [15:0] w_nx;
  logic [15:0] w_ny;
  logic        w_in_x;
  logic        w_in_y;

  // Biased neighbour coordinates and per-axis range tests
  always_comb begin
    w_xp1  = 16'(i_x) + 16'(slot_col(i_slot));
    w_yp1  = 16'(i_y) + 16'(slot_row(i_slot));
    w_in_x = (w_xp1 != 16'd0) && (w_xp1 <= 16'(W));
    w_in_y = (w_yp1 != 16'd0) && (w_yp1 <= 16'(H));
  end

  // Unbias, wrapping around the torus edges when enabled
  always_comb begin
    w_nx = w_xp1 - 16'd1;
    w_ny = w_yp1 - 16'd1;
    if (WRAP != 0) begin
      if (w_xp1 == 16'd0)       w_nx = 16'(W - 1);
      else if (w_xp1 > 16'(W))  w_nx = 16'd0;
      if (w_yp1 == 16'd0)       w_ny = 16'(H - 1);
      else if (w_yp1 > 16'(H))  w_ny = 16'd0;
    end
  end

  // Linear address and in-grid flag (always in-grid on a torus)
  always_comb begin
    o_addr    = AW'(32'(w_ny) * 32'(W) + 32'(w_nx));
    o_in_grid = (WRAP != 0) ? 1'b1 : (w_in_x && w_in_y);
  end

endmodule

// File: rtl/game_generation_ctrl.sv
// One Game-of-Life generation: for each cell, fetch its 3x3 neighbourhood
// from the current bank, hand it to the evaluator, write the result to the
// other bank; swap banks once the whole grid has been processed.
module game_generation_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int W    = 8,
  parameter int H    = 8,
  parameter int WRAP = 0,
  parameter int AW   = $clog2(W*H)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [15:0]         gen_count,
  output logic                bank_sel,
  output logic                rd_en,
  output logic [AW-1:0]       rd_addr,
  input  logic                rd_data,
  output logic                wr_en,
  output logic [AW-1:0]       wr_addr,
  output logic                wr_data,
  output logic [WIN_BITS-1:0] win,
  output logic                win_vld,
  input  logic                res,
  input  logic                res_vld,
  output logic                err
);

  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);

  state_t              r_state;
  logic [XW-1:0]       r_x;
  logic [YW-1:0]       r_y;
  logic [3:0]          r_slot;
  logic                r_prev_rd;
  logic                r_bank;
  logic [15:0]         r_gen;
  logic                r_err;
  logic [WIN_BITS-1:0] r_win;

  logic [AW-1:0]       w_nb_addr;
  logic                w_nb_in;
  logic                w_issue;
  logic                w_last_x;
  logic                w_last_y;
  logic [AW-1:0]       w_cell_addr;

  game_neigh_addr #(
    .W    (W),
    .H    (H),
    .WRAP (WRAP),
    .AW   (AW),
    .XW   (XW),
    .YW   (YW)
  ) u_neigh (
    .i_x       (r_x),
    .i_y       (r_y),
    .i_slot    (r_slot),
    .o_addr    (w_nb_addr),
    .o_in_grid (w_nb_in)
  );

  // Read issue qualification and current-cell bookkeeping
  always_comb begin
    w_issue     = (r_state == ST_FETCH) && (r_slot <= 4'(FETCH_LAST_READ)) && w_nb_in;
    w_last_x    = (r_x == XW'(W - 1));
    w_last_y    = (r_y == YW'(H - 1));
    w_cell_addr = AW'(32'(r_y) * 32'(W) + 32'(r_x));
  end

  // Sequencer: walks every cell through FETCH -> EVAL -> WAIT, then DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_x       <= '0;
      r_y       <= '0;
      r_slot    <= '0;
      r_prev_rd <= 1'b0;
      r_bank    <= 1'b0;
      r_gen     <= '0;
      r_err     <= 1'b0;
      r_win     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_x       <= '0;
            r_y       <= '0;
            r_slot    <= '0;
            r_prev_rd <= 1'b0;
            r_state   <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          // Data for slot i-1 arrives now; skipped (out-of-grid) slots read as dead
          if (r_slot != 4'd0) r_win[r_slot - 4'd1] <= r_prev_rd & rd_data;
          r_prev_rd <= w_issue;
          if (r_slot == 4'(FETCH_SLOTS - 1)) r_state <= ST_EVAL;
          else                               r_slot  <= r_slot + 4'd1;
        end
        ST_EVAL: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!res_vld) r_err <= 1'b1;
          r_slot <= '0;
          if (w_last_x && w_last_y) begin
            r_x     <= '0;
            r_y     <= '0;
            r_state <= ST_DONE;
          end else begin
            if (w_last_x) begin
              r_x <= '0;
              r_y <= r_y + 1'b1;
            end else begin
              r_x <= r_x + 1'b1;
            end
            r_state <= ST_FETCH;
          end
        end
        ST_DONE: begin
          r_bank  <= ~r_bank;
          r_gen   <= r_gen + 16'd1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Output decode; address buses are held at zero when not strobed
  always_comb begin
    busy      = (r_state != ST_IDLE);
    done      = (r_state == ST_DONE);
    gen_count = r_gen;
    bank_sel  = r_bank;
    rd_en     = w_issue;
    rd_addr   = w_issue ? w_nb_addr : '0;
    wr_en     = (r_state == ST_WAIT);
    wr_addr   = (r_state == ST_WAIT) ? w_cell_addr : '0;
    wr_data   = (r_state == ST_WAIT) & res;
    win       = r_win;
    win_vld   = (r_state == ST_EVAL);
    err       = r_err;
  end

endmodule

// File: tb/tb_game_generation_ctrl.sv
// Directed bench: 5x5 grid with dead edges (instance a) and 5x5 torus
// (instance b), with bench-side bank memories and a registered Life
// evaluator stub.
module tb_game_generation_ctrl;
  import game_ctrl_pkg::*;

  localparam logic [24:0] VERT  = 25'h0021080; // (2,1),(2,2),(2,3)
  localparam logic [24:0] HORZ  = 25'h0003800; // (1,2),(2,2),(3,2)
  localparam logic [24:0] BLOCK = 25'h0000063; // (0,0),(1,0),(0,1),(1,1)
  localparam logic [24:0] GLID  = 25'h0001C82; // (1,0),(2,1),(0,2),(1,2),(2,2)
  localparam logic [24:0] GLID4 = 25'h0072080; // glider moved by (+1,+1)

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance a: WRAP=0
  logic        a_start = 1'b0;
  logic        a_busy, a_done, a_bank, a_rd_en, a_wr_en, a_wr_data, a_win_vld, a_err;
  logic [15:0] a_gen;
  logic [4:0]  a_rd_addr, a_wr_addr;
  logic [8:0]  a_win;
  logic        a_rd_data, a_res, a_res_vld;

  // instance b: WRAP=1
  logic        b_start = 1'b0;
  logic        b_busy, b_done, b_bank, b_rd_en, b_wr_en, b_wr_data, b_win_vld, b_err;
  logic [15:0] b_gen;
  logic [4:0]  b_rd_addr, b_wr_addr;
  logic [8:0]  b_win;
  logic        b_rd_data, b_res, b_res_vld;

  game_generation_ctrl #(.W(5), .H(5), .WRAP(0)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
    .gen_count(a_gen), .bank_sel(a_bank), .rd_en(a_rd_en), .rd_addr(a_rd_addr),
    .rd_data(a_rd_data), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .win(a_win), .win_vld(a_win_vld), .res(a_res), .res_vld(a_res_vld), .err(a_err)
  );

  game_generation_ctrl #(.W(5), .H(5), .WRAP(1)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
    .gen_count(b_gen), .bank_sel(b_bank), .rd_en(b_rd_en), .rd_addr(b_rd_addr),
    .rd_data(b_rd_data), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .win(b_win), .win_vld(b_win_vld), .res(b_res), .res_vld(b_res_vld), .err(b_err)
  );

  logic [24:0] mem_a [0:1];
  logic [24:0] mem_b [0:1];
  int a_evals = 0;
  int drop_at = -1;

  function automatic logic life(input logic [8:0] w);
    int c;
    c = 0;
    for (int k = 0; k < 9; k++) if (k != WIN_CENTRE && w[k]) c++;
    return (c == 3) || (w[WIN_CENTRE] && c == 2);
  endfunction

  // bank memories (registered read) and evaluator stubs
  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= mem_a[a_bank][a_rd_addr];
    if (a_wr_en) mem_a[~a_bank][a_wr_addr] = a_wr_data;
    a_res     <= life(a_win);
    a_res_vld <= a_win_vld && (a_evals != drop_at);
    if (a_win_vld) a_evals <= a_evals + 1;
    if (b_rd_en) b_rd_data <= mem_b[b_bank][b_rd_addr];
    if (b_wr_en) mem_b[~b_bank][b_wr_addr] = b_wr_data;
    b_res     <= life(b_win);
    b_res_vld <= b_win_vld;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // per-run measurements of instance a
  int         m_busy, m_done, m_rd_cnt, m_rd_bad, m_timeout;
  logic [8:0] m_win0;
  logic       m_seen_win;

  // one generation on instance a; optional extra start pulse at busy cycle poke_at
  task automatic run_a(input int poke_at);
    m_busy = 0; m_done = 0; m_rd_cnt = 0; m_rd_bad = 0; m_timeout = 0;
    m_win0 = '0; m_seen_win = 1'b0;
    @(negedge clk) a_start = 1'b1;
    @(negedge clk) a_start = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (!a_busy) break;
      m_busy++;
      if (a_done) m_done++;
      if (m_busy <= 10 && a_rd_en) begin
        m_rd_cnt++;
        if (!(a_rd_addr inside {5'd0, 5'd1, 5'd5, 5'd6})) m_rd_bad++;
      end
      if (a_win_vld && !m_seen_win) begin
        m_win0 = a_win;
        m_seen_win = 1'b1;
      end
      a_start = (m_busy == poke_at);
      @(negedge clk);
    end
    a_start = 1'b0;
    if (a_busy) m_timeout = 1;
    check_val("a_timeout", m_timeout, 0);
    $display("run a: busy=%0d done=%0d gen=%0d bank=%0d err=%0d",
             m_busy, m_done, a_gen, a_bank, a_err);
  endtask

  // one generation on instance b
  task automatic run_b();
    int to;
    to = 0;
    @(negedge clk) b_start = 1'b1;
    @(negedge clk) b_start = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (!b_busy) break;
      @(negedge clk);
    end
    if (b_busy) to = 1;
    check_val("b_timeout", to, 0);
    $display("run b: gen=%0d bank=%0d grid=0x%0h", b_gen, b_bank, mem_b[b_bank]);
  endtask

  initial begin
    logic [8:0] masked;
    logic       exp_bank;

    mem_a[0] = '0; mem_a[1] = '0; mem_b[0] = '0; mem_b[1] = '0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", a_busy, 0);
    check_val("rst_done", a_done, 0);
    check_val("rst_gen", a_gen, 0);
    check_val("rst_bank", a_bank, 0);
    check_val("rst_rd", {a_rd_en, a_rd_addr}, 0);
    check_val("rst_wr", {a_wr_en, a_wr_addr, a_wr_data}, 0);
    check_val("rst_win", {a_win_vld, a_win}, 0);
    check_val("rst_err", a_err, 0);
    rst = 1'b0;

    // blinker
    mem_a[0] = VERT;
    run_a(-1);
    check_val("blk_busy", m_busy, CYCLES_PER_CELL * 25 + 1);
    check_val("blk_done", m_done, 1);
    check_val("blk_bank", a_bank, 1);
    check_val("blk_gen", a_gen, 1);
    check_val("blk_next", mem_a[1], HORZ);
    check_val("blk_src_kept", mem_a[0], VERT);

    // block still life, three generations
    mem_a[1] = BLOCK;
    exp_bank = 1'b1;
    for (int g = 0; g < 3; g++) begin
      run_a(-1);
      exp_bank = ~exp_bank;
      masked = m_win0 & 9'h04F;
      check_val("still_bank", a_bank, exp_bank);
      check_val("still_gen", a_gen, 32'(2 + g));
      check_val("still_grid", mem_a[exp_bank], BLOCK);
      check_val("corner_rd_cnt", m_rd_cnt, 4);
      check_val("corner_rd_oog", m_rd_bad, 0);
      check_val("corner_win_edge", masked, 0);
      check_val("corner_win", m_win0, 9'h1B0);
    end

    // start pulsed 50 cycles in is ignored
    mem_a[0] = VERT;
    run_a(50);
    check_val("poke_done", m_done, 1);
    check_val("poke_busy", m_busy, 301);
    check_val("poke_gen", a_gen, 5);
    check_val("poke_grid", mem_a[1], HORZ);

    // missing res_vld on one cell sets sticky err
    drop_at = a_evals + 7;
    run_a(-1);
    drop_at = -1;
    check_val("err_set", a_err, 1);
    check_val("err_done", m_done, 1);
    check_val("err_gen", a_gen, 6);
    check_val("err_grid", mem_a[0], VERT);
    run_a(-1);
    check_val("err_sticky", a_err, 1);
    check_val("err_gen2", a_gen, 7);

    // reset mid-generation
    @(negedge clk) a_start = 1'b1;
    @(negedge clk) a_start = 1'b0;
    repeat (99) @(negedge clk);
    check_val("pre_rst_busy", a_busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check_val("mid_rst_busy", a_busy, 0);
    check_val("mid_rst_bank", a_bank, 0);
    check_val("mid_rst_gen", a_gen, 0);
    check_val("mid_rst_err", a_err, 0);
    rst = 1'b0;
    mem_a[0] = VERT; mem_a[1] = '0;
    run_a(-1);
    check_val("post_rst_busy", m_busy, 301);
    check_val("post_rst_gen", a_gen, 1);
    check_val("post_rst_bank", a_bank, 1);
    check_val("post_rst_grid", mem_a[1], HORZ);
    check_val("post_rst_err", a_err, 0);

    // glider on the torus, 20 generations
    mem_b[0] = GLID; mem_b[1] = '0;
    for (int g = 0; g < 20; g++) begin
      run_b();
      if (g == 3) check_val("glider_g4", mem_b[0], GLID4);
    end
    check_val("glider_grid", mem_b[0], GLID);
    check_val("glider_gen", b_gen, 20);
    check_val("glider_bank", b_bank, 0);
    check_val("glider_err", b_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
